// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: issue-side hazard tracker for a 5-stage MIPS pipeline.
// It shadows the destination register of every instruction leaving ID
// through EX, MEM and WB slots. The slots advance with the shared stall bus.
// Each cycle it reports the youngest in-flight writer for each ID source
// port and raises the load-use stall request for CTRL.
module pipe_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_we,
    input  logic [4:0]  id_waddr,
    input  logic        id_is_load,
    input  logic        rs_re,
    input  logic [4:0]  rs_raddr,
    input  logic        rt_re,
    input  logic [4:0]  rt_raddr,
    output logic [1:0]  rs_hit,
    output logic [1:0]  rt_hit,
    output logic        stall_for_load,
    output logic [31:0] pending_mask,
    output logic [31:0] lu_stall_cnt
);

    // One in-flight writer record.
    typedef struct packed {
        logic       valid;
        logic [4:0] waddr;
        logic       is_load;
    } slot_t;

    // Stage holding the youngest matching writer.
    typedef enum logic [1:0] {
        HIT_NONE = 2'd0,
        HIT_EX   = 2'd1,
        HIT_MEM  = 2'd2,
        HIT_WB   = 2'd3
    } hit_e;

    localparam slot_t EMPTY_SLOT = '0;

    // Stall bus bit positions.
    localparam int ST_ID  = 2;
    localparam int ST_EX  = 3;
    localparam int ST_MEM = 4;
    localparam int ST_WB  = 5;

    slot_t       r_ex;
    slot_t       r_mem;
    slot_t       r_wb;
    logic [31:0] r_lu_stall_cnt;

    slot_t       w_capture;
    logic        w_rs_ex, w_rs_mem, w_rs_wb;
    logic        w_rt_ex, w_rt_mem, w_rt_wb;
    logic        w_stall_for_load;
    logic [31:0] w_pending_mask;

    // A source port matches a slot only when it is used, is not $0, and the
    // slot holds a real writer of that register.
    function automatic logic slot_match(input slot_t s, input logic re,
                                        input logic [4:0] raddr);
        return re && (raddr != 5'd0) && s.valid && (s.waddr == raddr);
    endfunction

    // The youngest writer wins: EX before MEM before WB.
    function automatic hit_e hit_select(input logic m_ex, input logic m_mem,
                                        input logic m_wb);
        if (m_ex)       return HIT_EX;
        else if (m_mem) return HIT_MEM;
        else if (m_wb)  return HIT_WB;
        else            return HIT_NONE;
    endfunction

    // Build the record that enters EX when ID is allowed to advance.
    // Writes to $0 are discarded here, so no slot ever tracks $0.
    always_comb begin
        w_capture         = EMPTY_SLOT;
        w_capture.valid   = id_valid && id_we && (id_waddr != 5'd0);
        w_capture.waddr   = id_waddr;
        w_capture.is_load = id_is_load;
    end

    // Per-port slot matches. ID itself is not a slot, so an instruction
    // never matches its own destination.
    always_comb begin
        w_rs_ex  = slot_match(r_ex,  rs_re, rs_raddr);
        w_rs_mem = slot_match(r_mem, rs_re, rs_raddr);
        w_rs_wb  = slot_match(r_wb,  rs_re, rs_raddr);
        w_rt_ex  = slot_match(r_ex,  rt_re, rt_raddr);
        w_rt_mem = slot_match(r_mem, rt_re, rt_raddr);
        w_rt_wb  = slot_match(r_wb,  rt_re, rt_raddr);
    end

    // A load still in EX cannot forward yet, so a dependent ID instruction
    // must wait. Once the load reaches MEM or WB its data is forwarded.
    always_comb begin
        w_stall_for_load = id_valid &&
                           ((w_rs_ex && r_ex.is_load) ||
                            (w_rt_ex && r_ex.is_load));
    end

    // Mark every register that some valid slot is about to write.
    always_comb begin
        // NOTE: assign a default before any conditional write in always_comb;
        // a path that leaves a bit unassigned would infer a latch.
        w_pending_mask = '0;
        if (r_ex.valid)  w_pending_mask[r_ex.waddr]  = 1'b1;
        if (r_mem.valid) w_pending_mask[r_mem.waddr] = 1'b1;
        if (r_wb.valid)  w_pending_mask[r_wb.waddr]  = 1'b1;
        w_pending_mask[0] = 1'b0;
    end

    // Advance the slots with the stall bus. At each boundary the downstream
    // slot loads, becomes a bubble, or holds. WB content retires simply by
    // being overwritten.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every slot
        // then samples the pre-edge value of its upstream neighbour, which
        // is what makes the three slots shift in one edge.
        if (!rst) begin
            r_ex  <= EMPTY_SLOT;
            r_mem <= EMPTY_SLOT;
            r_wb  <= EMPTY_SLOT;
        end else if (flush) begin
            r_ex.valid  <= 1'b0;
            r_mem.valid <= 1'b0;
            r_wb.valid  <= 1'b0;
        end else begin
            // ID -> EX
            if (!stall[ST_ID])
                r_ex <= w_capture;
            else if (!stall[ST_EX])
                r_ex <= EMPTY_SLOT;

            // EX -> MEM
            if (!stall[ST_EX])
                r_mem <= r_ex;
            else if (!stall[ST_MEM])
                r_mem <= EMPTY_SLOT;

            // MEM -> WB
            if (!stall[ST_MEM])
                r_wb <= r_mem;
            else if (!stall[ST_WB])
                r_wb <= EMPTY_SLOT;
        end
    end

    // Count load-use stall cycles. The count saturates at all-ones and is
    // deliberately left untouched by flush.
    always_ff @(posedge clk) begin
        if (!rst)
            r_lu_stall_cnt <= '0;
        else if (w_stall_for_load && (r_lu_stall_cnt != '1))
            r_lu_stall_cnt <= r_lu_stall_cnt + 32'd1;
    end

    assign rs_hit         = hit_select(w_rs_ex, w_rs_mem, w_rs_wb);
    assign rt_hit         = hit_select(w_rt_ex, w_rt_mem, w_rt_wb);
    assign stall_for_load = w_stall_for_load;
    assign pending_mask   = w_pending_mask;
    assign lu_stall_cnt   = r_lu_stall_cnt;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard. The driver issues one directed vector per cycle
// and queues that cycle's hand-computed outputs. The monitor pops the queue
// and compares on the falling edge.
module tb_pipe_scoreboard;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        id_valid;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        id_is_load;
    logic        rs_re;
    logic [4:0]  rs_raddr;
    logic        rt_re;
    logic [4:0]  rt_raddr;
    logic [1:0]  rs_hit;
    logic [1:0]  rt_hit;
    logic        stall_for_load;
    logic [31:0] pending_mask;
    logic [31:0] lu_stall_cnt;

    typedef struct {
        string       nm;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic        sfl;
        logic [31:0] pend;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_we          (id_we),
        .id_waddr       (id_waddr),
        .id_is_load     (id_is_load),
        .rs_re          (rs_re),
        .rs_raddr       (rs_raddr),
        .rt_re          (rt_re),
        .rt_raddr       (rt_raddr),
        .rs_hit         (rs_hit),
        .rt_hit         (rt_hit),
        .stall_for_load (stall_for_load),
        .pending_mask   (pending_mask),
        .lu_stall_cnt   (lu_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: compare all outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.nm, ".rs_hit"},         32'(rs_hit),         32'(e.rs));
            check({e.nm, ".rt_hit"},         32'(rt_hit),         32'(e.rt));
            check({e.nm, ".stall_for_load"}, 32'(stall_for_load), 32'(e.sfl));
            check({e.nm, ".pending_mask"},   pending_mask,        e.pend);
            check({e.nm, ".lu_stall_cnt"},   lu_stall_cnt,        e.cnt);
        end
    end

    // Drive one cycle of inputs and queue that cycle's expected outputs.
    task automatic cyc(input string nm, input logic [5:0] st, input logic fl,
                       input logic v, input logic we, input logic [4:0] wa,
                       input logic ld,
                       input logic rsre, input logic [4:0] rsa,
                       input logic rtre, input logic [4:0] rta,
                       input logic [1:0] ers, input logic [1:0] ert,
                       input logic esfl, input logic [31:0] epend,
                       input logic [31:0] ecnt);
        exp_t e;
        stall      = st;
        flush      = fl;
        id_valid   = v;
        id_we      = we;
        id_waddr   = wa;
        id_is_load = ld;
        rs_re      = rsre;
        rs_raddr   = rsa;
        rt_re      = rtre;
        rt_raddr   = rta;
        e.nm   = nm;
        e.rs   = ers;
        e.rt   = ert;
        e.sfl  = esfl;
        e.pend = epend;
        e.cnt  = ecnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset cycle with random inputs; every output must read zero.
    task automatic rst_cyc(input string nm);
        exp_t e;
        rst        = 1'b0;
        stall      = 6'($urandom);
        flush      = 1'($urandom);
        id_valid   = 1'($urandom);
        id_we      = 1'($urandom);
        id_waddr   = 5'($urandom);
        id_is_load = 1'($urandom);
        rs_re      = 1'($urandom);
        rs_raddr   = 5'($urandom);
        rt_re      = 1'($urandom);
        rt_raddr   = 5'($urandom);
        e.nm   = nm;
        e.rs   = 2'd0;
        e.rt   = 2'd0;
        e.sfl  = 1'b0;
        e.pend = 32'd0;
        e.cnt  = 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        stall = '0; flush = 0; id_valid = 0; id_we = 0; id_waddr = '0;
        id_is_load = 0; rs_re = 0; rs_raddr = '0; rt_re = 0; rt_raddr = '0;
        @(posedge clk);
        #1;
        rst_cyc("reset_a");
        rst_cyc("reset_b");
        rst = 1'b1;

        //  name                 stall      fl v we wa ld rsre rsa rtre rta ers ert sfl pend          cnt
        cyc("rel_idle",          6'b000000, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0, 32'h0,        32'h0);
        // ALU dependence chain on $5, including a self-read at issue.
        cyc("alu_issue5_self",   6'b000000, 0, 1, 1, 5, 0, 1,  5, 0,  0,  0, 0, 0, 32'h0,        32'h0);
        cyc("alu_hit_ex",        6'b000000, 0, 1, 0, 0, 0, 1,  5, 0,  0,  1, 0, 0, 32'h20,       32'h0);
        cyc("alu_hit_mem",       6'b000000, 0, 1, 0, 0, 0, 1,  5, 0,  0,  2, 0, 0, 32'h20,       32'h0);
        cyc("alu_hit_wb",        6'b000000, 0, 1, 0, 0, 0, 1,  5, 0,  0,  3, 0, 0, 32'h20,       32'h0);
        cyc("alu_gone",          6'b000000, 0, 1, 0, 0, 0, 1,  5, 0,  0,  0, 0, 0, 32'h0,        32'h0);
        // Load-use on rt: one stall cycle, then forwarding from MEM.
        cyc("lw8_issue",         6'b000000, 0, 1, 1, 8, 1, 0,  0, 0,  0,  0, 0, 0, 32'h0,        32'h0);
        cyc("lu_stall",          6'b000111, 0, 1, 1, 9, 0, 1,  1, 1,  8,  0, 1, 1, 32'h100,      32'h0);
        cyc("lu_fwd_mem",        6'b000000, 0, 1, 1, 9, 0, 1,  1, 1,  8,  0, 2, 0, 32'h100,      32'h1);
        cyc("lu_after",          6'b000000, 0, 1, 0, 0, 0, 1,  9, 1,  8,  1, 3, 0, 32'h300,      32'h1);
        cyc("drain_a",           6'b000000, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0, 32'h200,      32'h1);
        cyc("drain_b",           6'b000000, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0, 32'h200,      32'h1);
        // Two writers of $3; $0 as destination and as source.
        cyc("w3_first",          6'b000000, 0, 1, 1, 3, 0, 0,  0, 0,  0,  0, 0, 0, 32'h0,        32'h1);
        cyc("w3_second",         6'b000000, 0, 1, 1, 3, 0, 1,  3, 1,  0,  1, 0, 0, 32'h8,        32'h1);
        cyc("w3_ex_mem_w0",      6'b000000, 0, 1, 1, 0, 0, 1,  3, 1,  0,  1, 0, 0, 32'h8,        32'h1);
        cyc("w3_mem_wb",         6'b000000, 0, 0, 0, 0, 0, 1,  3, 1,  0,  2, 0, 0, 32'h8,        32'h1);
        cyc("w3_wb_only",        6'b000000, 0, 0, 0, 0, 0, 1,  3, 0,  0,  3, 0, 0, 32'h8,        32'h1);
        // Fill all slots, then hold, partial hold, and EX bubble.
        cyc("fill10",            6'b000000, 0, 1, 1, 10, 0, 0, 0, 0,  0,  0, 0, 0, 32'h0,        32'h1);
        cyc("fill11",            6'b000000, 0, 1, 1, 11, 0, 0, 0, 0,  0,  0, 0, 0, 32'h400,      32'h1);
        cyc("fill12",            6'b000000, 0, 1, 1, 12, 1, 0, 0, 0,  0,  0, 0, 0, 32'hC00,      32'h1);
        cyc("hold_all_1",        6'b111111, 0, 1, 1, 13, 0, 1, 11, 1, 10, 2, 3, 0, 32'h1C00,     32'h1);
        cyc("hold_all_2",        6'b111111, 0, 1, 1, 13, 0, 1, 11, 1, 10, 2, 3, 0, 32'h1C00,     32'h1);
        cyc("hold_all_3",        6'b111111, 0, 1, 1, 13, 0, 1, 11, 1, 10, 2, 3, 0, 32'h1C00,     32'h1);
        cyc("ex_hold_mem_bub",   6'b001111, 0, 1, 1, 13, 0, 1, 11, 1, 10, 2, 3, 0, 32'h1C00,     32'h1);
        cyc("ex_bubble",         6'b000111, 0, 1, 1, 13, 0, 1, 11, 1, 10, 3, 0, 0, 32'h1800,     32'h1);
        cyc("after_bubble",      6'b000000, 0, 1, 1, 13, 0, 1, 12, 1, 11, 2, 0, 0, 32'h1000,     32'h1);
        cyc("seen_13",           6'b000000, 0, 0, 0, 0, 0,  1, 13, 1, 12, 1, 3, 0, 32'h3000,     32'h1);
        // Flush with all slots valid, together with a stall.
        cyc("fill20",            6'b000000, 0, 1, 1, 20, 0, 0, 0, 0,  0,  0, 0, 0, 32'h2000,     32'h1);
        cyc("fill21",            6'b000000, 0, 1, 1, 21, 0, 0, 0, 0,  0,  0, 0, 0, 32'h102000,   32'h1);
        cyc("fill22",            6'b000000, 0, 1, 1, 22, 0, 0, 0, 0,  0,  0, 0, 0, 32'h300000,   32'h1);
        cyc("flush_all",         6'b000111, 1, 1, 1, 23, 0, 1, 22, 1, 20, 1, 3, 0, 32'h700000,   32'h1);
        cyc("post_flush",        6'b000000, 0, 1, 0, 0, 0,  1, 22, 1, 21, 0, 0, 0, 32'h0,        32'h1);
        // A load-use stall cycle that coincides with flush still counts.
        cyc("lw4",               6'b000000, 0, 1, 1, 4, 1,  0, 0, 0,  0,  0, 0, 0, 32'h0,        32'h1);
        cyc("flush_lu",          6'b000111, 1, 1, 1, 9, 0,  1, 4, 0,  0,  1, 0, 1, 32'h10,       32'h1);
        cyc("flush_cnt",         6'b000000, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 32'h0,        32'h2);

        // Preload the counter near saturation, then run three load-use stalls.
        dut.r_lu_stall_cnt = 32'hFFFF_FFFE;
        cyc("sat_lw8",           6'b000000, 0, 1, 1, 8, 1,  0, 0, 0,  0,  0, 0, 0, 32'h0,        32'hFFFF_FFFE);
        cyc("sat_lu1",           6'b000111, 0, 1, 1, 9, 0,  1, 8, 0,  0,  1, 0, 1, 32'h100,      32'hFFFF_FFFE);
        cyc("sat_fwd1",          6'b000000, 0, 1, 1, 9, 0,  1, 8, 0,  0,  2, 0, 0, 32'h100,      32'hFFFF_FFFF);
        cyc("sat_lw8b",          6'b000000, 0, 1, 1, 8, 1,  0, 0, 0,  0,  0, 0, 0, 32'h300,      32'hFFFF_FFFF);
        cyc("sat_lu2",           6'b000111, 0, 1, 0, 0, 0,  0, 0, 1,  8,  0, 1, 1, 32'h300,      32'hFFFF_FFFF);
        cyc("sat_fwd2",          6'b000000, 0, 1, 0, 0, 0,  0, 0, 1,  8,  0, 2, 0, 32'h300,      32'hFFFF_FFFF);
        cyc("sat_lw7",           6'b000000, 0, 1, 1, 7, 1,  0, 0, 0,  0,  0, 0, 0, 32'h100,      32'hFFFF_FFFF);
        cyc("sat_lu3",           6'b000111, 0, 1, 0, 0, 0,  1, 7, 1,  7,  1, 1, 1, 32'h80,       32'hFFFF_FFFF);
        cyc("sat_fwd3",          6'b000000, 0, 1, 0, 0, 0,  1, 7, 1,  7,  2, 2, 0, 32'h80,       32'hFFFF_FFFF);
        cyc("sat_idle",          6'b000000, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 32'h80,       32'hFFFF_FFFF);
        // Reset mid-stream beats a full stall.
        cyc("mid_issue15",       6'b000000, 0, 1, 1, 15, 0, 0, 0, 0,  0,  0, 0, 0, 32'h0,        32'hFFFF_FFFF);
        rst = 1'b0;
        cyc("mid_rst",           6'b111111, 0, 0, 0, 0, 0,  1, 15, 0, 0,  1, 0, 0, 32'h8000,     32'hFFFF_FFFF);
        rst = 1'b1;
        cyc("post_rst",          6'b000000, 0, 0, 0, 0, 0,  1, 15, 0, 0,  0, 0, 0, 32'h0,        32'h0);

        // Give the monitor a bounded window to consume what is left.
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
